// File: rtl/esp32_prog_bridge.sv
// FTDI <-> ESP32 programming bridge for ULX3S: UART passthru,
// filtered DTR/RTS decode, strap-hold FSM and button readback SPI.
module esp32_prog_bridge #(
  parameter int C_FILTER     = 4,
  parameter int C_HOLD_BITS  = 17,
  parameter int C_BTN_WIDTH  = 7,
  parameter int C_SPI_WIDTH  = 8,
  parameter int C_SHIFT_EDGE = 0
) (
  input  logic                   clk_25MHz,
  input  logic                   rstn,
  input  logic                   ftdi_txd,
  output logic                   ftdi_rxd,
  input  logic                   wifi_txd,
  output logic                   wifi_rxd,
  input  logic                   ftdi_ndtr,
  input  logic                   ftdi_nrts,
  input  logic [C_BTN_WIDTH-1:0] btn,
  output logic                   wifi_en,
  output logic                   wifi_gpio0,
  output logic                   strap_oe,
  output logic                   strap_val,
  input  logic                   spi_csn,
  input  logic                   spi_sclk,
  output logic                   spi_miso,
  output logic                   spi_miso_oe,
  output logic                   prog_active
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  localparam logic [7:0] FLT_LAST = 8'(C_FILTER - 1);
  localparam logic [7:0] FLT_ONE  = 8'd1;

  localparam logic [C_HOLD_BITS-1:0] HOLD_LAST = '1;
  localparam logic [C_HOLD_BITS-1:0] HOLD_ONE  = 1;

  localparam int W = C_SPI_WIDTH;

  assign ftdi_rxd = wifi_txd;
  assign wifi_rxd = ftdi_txd;

  logic [1:0] pin_m;
  logic [1:0] pin_s;
  logic [1:0] flt;
  logic [7:0] flt_cnt;
  logic [1:0] dec;
  logic [1:0] dec_q;
  logic       trig;

  always_ff @(posedge clk_25MHz or negedge rstn) begin
    if (!rstn) begin
      pin_m <= 2'b11;
      pin_s <= 2'b11;
    end else begin
      pin_m <= {ftdi_ndtr, ftdi_nrts};
      pin_s <= pin_m;
    end
  end

  // A change is accepted only after C_FILTER unbroken cycles of disagreement
  always_ff @(posedge clk_25MHz or negedge rstn) begin
    if (!rstn) begin
      flt     <= 2'b11;
      flt_cnt <= 8'd0;
    end else if (pin_s == flt) begin
      flt_cnt <= 8'd0;
    end else if (flt_cnt == FLT_LAST) begin
      flt     <= pin_s;
      flt_cnt <= 8'd0;
    end else begin
      flt_cnt <= flt_cnt + FLT_ONE;
    end
  end

  always_comb begin
    dec = 2'b11;
    unique case (1'b1)
      (flt == 2'b10): dec = 2'b01;
      (flt == 2'b01): dec = 2'b10;
      default:        dec = 2'b11;
    endcase
  end

  assign trig = (dec_q == 2'b11) && (dec == 2'b01);

  always_ff @(posedge clk_25MHz or negedge rstn) begin
    if (!rstn) begin
      dec_q      <= 2'b11;
      wifi_en    <= 1'b1;
      wifi_gpio0 <= 1'b1;
    end else begin
      dec_q      <= dec;
      wifi_en    <= dec[1];
      wifi_gpio0 <= dec[0] & btn[0];
    end
  end

  logic [0:0]             state;
  logic [0:0]             state_n;
  logic [C_HOLD_BITS-1:0] hold_cnt;
  logic [C_HOLD_BITS-1:0] hold_cnt_n;

  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    unique case (state)
      S_IDLE: begin
        if (trig) begin
          state_n    = S_HOLD;
          hold_cnt_n = '0;
        end
      end
      S_HOLD: begin
        if (trig) begin
          hold_cnt_n = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_n    = S_IDLE;
          hold_cnt_n = '0;
        end else begin
          hold_cnt_n = hold_cnt + HOLD_ONE;
        end
      end
      default: begin
        state_n    = S_IDLE;
        hold_cnt_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk_25MHz or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      hold_cnt    <= '0;
      strap_oe    <= 1'b0;
      strap_val   <= 1'b0;
      prog_active <= 1'b0;
    end else begin
      state       <= state_n;
      hold_cnt    <= hold_cnt_n;
      strap_oe    <= (state_n == S_HOLD);
      strap_val   <= (state_n == S_HOLD) & dec[0];
      prog_active <= (state_n == S_HOLD);
    end
  end

  logic         csn_m;
  logic         csn_s;
  logic         sclk_m;
  logic         sclk_s;
  logic         sclk_q;
  logic         act;
  logic [W-1:0] load;
  logic [W-1:0] shreg;

  always_ff @(posedge clk_25MHz or negedge rstn) begin
    if (!rstn) begin
      csn_m  <= 1'b1;
      csn_s  <= 1'b1;
      sclk_m <= 1'b0;
      sclk_s <= 1'b0;
      sclk_q <= 1'b0;
    end else begin
      csn_m  <= spi_csn;
      csn_s  <= csn_m;
      sclk_m <= spi_sclk;
      sclk_s <= sclk_m;
      sclk_q <= sclk_s;
    end
  end

  assign act = (C_SHIFT_EDGE != 0) ? (sclk_q & ~sclk_s)
                                   : (sclk_s & ~sclk_q);

  always_comb begin
    load = '0;
    load[C_BTN_WIDTH-1:0] = btn;
  end

  // Rotating (not shifting) lets the master re-read past W edges
  always_ff @(posedge clk_25MHz or negedge rstn) begin
    if (!rstn) begin
      shreg <= '0;
    end else if (csn_s) begin
      shreg <= load;
    end else if (act) begin
      shreg <= {shreg[W-2:0], shreg[W-1]};
    end
  end

  assign spi_miso    = shreg[W-1];
  assign spi_miso_oe = ~csn_s;

endmodule
